l2tlb_resp: RTL and testbench
=============================

// Module: l2tlb_resp
// PURPOSE
// - L2-TLB-side responder for the L1 data TLB: accepts l1tlbtol2tlb_req fills, returns l2tlbtol1tlb_ack.
// - Tracks which hpaddr each L1 TLB currently holds in a direct-mapped residency table.
// - On a conflict it first evicts the old entry: snoop out, wait for l1tlbtol2tlb_sack, then ack the new fill.
// - Translation is identity in this phase:
//   - hpaddr = laddr[22:12]
//   - ppaddr = laddr[14:12]
// PARAMETERS
// - ENTRIES  16  residency slots, power of 2; index = hpaddr[$clog2(ENTRIES)-1:0]
// - VA_W     32  legal laddr width; any set laddr bit at or above VA_W is a fault
// PORTS
// - clk                       in   1                          clock
// - reset                     in   1                          async reset, ACTIVE-LOW
// - l1tlbtol2tlb_req_valid    in   1                          fill request valid
// - l1tlbtol2tlb_req_retry    out  1                          request back-pressure
// - l1tlbtol2tlb_req          in   $bits(I_l1tlbtol2tlb_req)  fields used: coreid, laddr
// - l2tlbtol1tlb_ack_valid    out  1                          fill response valid
// - l2tlbtol1tlb_ack_retry    in   1                          response back-pressure
// - l2tlbtol1tlb_ack          out  $bits(I_l2tlbtol1tlb_ack)  fields: coreid, hpaddr[10:0], ppaddr[2:0], fault[2:0]
// - l2tlbtol1tlb_snoop_valid  out  1                          eviction snoop valid
// - l2tlbtol1tlb_snoop_retry  in   1                          snoop back-pressure
// - l2tlbtol1tlb_snoop        out  $bits(I_l2tlbtol1tlb_snoop) field: hpaddr[10:0] being evicted
// - l1tlbtol2tlb_sack_valid   in   1                          snoop acknowledge valid
// - l1tlbtol2tlb_sack_retry   out  1                          tied 0
// - l1tlbtol2tlb_sack         in   $bits(I_l1tlbtol2tlb_sack) field: hpaddr[10:0]
// BEHAVIOUR
// - Handshake: a transfer occurs in a cycle with valid & ~retry.
//   - Sender holds valid and payload stable while retry is high.
//   - All outputs are registered.
// - Reset (reset==0, asynchronous):
//   - state=IDLE, all slots invalid.
//   - All *_valid outputs 0; ack/snoop payloads 0.
//   - req_retry=1 while in reset and 0 after it.
//   - Reset mid-operation abandons any pending snoop or ack.
// - Slot contents: valid bit plus tag = hpaddr[10:$clog2(ENTRIES)].
// - FSM: IDLE, SNOOP, WAIT_SACK, ACK.
// - req_retry = (state != IDLE). A request is accepted only in IDLE.
// - IDLE, on accept: latch coreid and laddr, then compute h = laddr[22:12].
//   - fault (laddr[63:VA_W] != 0): ack.fault=3'b001, hpaddr=0, ppaddr=0, table untouched -> ACK.
//   - hit (slot valid, tag match): -> ACK, table unchanged.
//   - slot invalid: install h -> ACK.
//   - conflict (valid, tag differs): snoop.hpaddr = old resident hpaddr -> SNOOP.
// - SNOOP: snoop_valid=1; on snoop transfer -> WAIT_SACK.
// - WAIT_SACK:
//   - sack_valid with sack.hpaddr == snooped hpaddr: install h -> ACK.
//   - Non-matching sack: dropped, state held.
// - ACK: ack_valid=1 with the computed fields; on ack transfer -> IDLE.
// - Sack in any state other than WAIT_SACK is dropped.
// - Latency:
//   - Non-conflict: request accepted cycle N -> ack_valid at N+1.
//   - Conflict: snoop_valid at N+1, matching sack at cycle M -> ack_valid at M+1.
//   - Ack back-to-back throughput: one request per 2 cycles.
// - Sack and snoop transfer in the same cycle: impossible by construction (WAIT_SACK follows SNOOP).
// - Only one transaction is outstanding; no queueing.
// TESTING
// - T1 reset: hold reset=0 -> all valids 0, req_retry=1; release reset -> req_retry=0.
// - T2 cold fill: req laddr=0x0000_5000, coreid=2 -> next cycle ack hpaddr=0x005, ppaddr=5, fault=0, coreid=2.
// - T3 hit under ack_retry: repeat T2 with ack_retry=1 for 3 cycles
//   -> ack held stable, req_retry=1 throughout, then IDLE.
// - T4 conflict: fill 0x0001_0000 (slot 0), then 0x0002_0000 (slot 0)
//   -> snoop hpaddr=0x010; send wrong sack 0x020 (ignored), then sack 0x010
//   -> ack hpaddr=0x020 one cycle later.
// - T5 fault: laddr bit 40 set -> ack fault=3'b001, no snoop; a later fill to the same slot sees it invalid.
// - T6 reset in WAIT_SACK: snoop pending, assert reset -> idle; refill of the same addr acks with no snoop.

Source files
------------

// File: rtl/l2tlb_resp.sv
// L2-TLB responder for the L1 data TLB: answers fill requests, tracks L1
// residency in a direct-mapped table and evicts conflicting entries by snoop.

package l2tlb_resp_pkg;
    localparam int CORE_W = 4;

    typedef struct packed {
        logic [CORE_W-1:0] coreid;
        logic [63:0]       laddr;
    } I_l1tlbtol2tlb_req;

    typedef struct packed {
        logic [CORE_W-1:0] coreid;
        logic [10:0]       hpaddr;
        logic [2:0]        ppaddr;
        logic [2:0]        fault;
    } I_l2tlbtol1tlb_ack;

    typedef struct packed {
        logic [10:0] hpaddr;
    } I_l2tlbtol1tlb_snoop;

    typedef struct packed {
        logic [10:0] hpaddr;
    } I_l1tlbtol2tlb_sack;
endpackage

module l2tlb_resp
    import l2tlb_resp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int VA_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                l1tlbtol2tlb_req_valid,
    output logic                l1tlbtol2tlb_req_retry,
    input  I_l1tlbtol2tlb_req   l1tlbtol2tlb_req,
    output logic                l2tlbtol1tlb_ack_valid,
    input  logic                l2tlbtol1tlb_ack_retry,
    output I_l2tlbtol1tlb_ack   l2tlbtol1tlb_ack,
    output logic                l2tlbtol1tlb_snoop_valid,
    input  logic                l2tlbtol1tlb_snoop_retry,
    output I_l2tlbtol1tlb_snoop l2tlbtol1tlb_snoop,
    input  logic                l1tlbtol2tlb_sack_valid,
    output logic                l1tlbtol2tlb_sack_retry,
    input  I_l1tlbtol2tlb_sack  l1tlbtol2tlb_sack
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 11 - IDX_W;

    typedef enum logic [1:0] {IDLE, SNOOP, WAIT_SACK, ACK} state_t;

    state_t                  state_q, state_d;
    logic [ENTRIES-1:0]      slot_valid_q;
    logic [TAG_W-1:0]        slot_tag_q [ENTRIES];
    logic [10:0]             cur_h_q, cur_h_d;
    logic [CORE_W-1:0]       cur_core_q, cur_core_d;
    I_l2tlbtol1tlb_ack       ack_q, ack_d;
    I_l2tlbtol1tlb_snoop     snoop_q, snoop_d;
    logic                    ack_valid_q, snoop_valid_q, req_retry_q;

    logic [10:0]             req_h;
    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic                    req_fault;
    logic                    inst_en;
    logic [IDX_W-1:0]        inst_idx;
    logic [TAG_W-1:0]        inst_tag;
    logic                    unused_laddr;

    assign req_h        = l1tlbtol2tlb_req.laddr[22:12];
    assign req_idx      = req_h[IDX_W-1:0];
    assign req_tag      = req_h[10:IDX_W];
    assign req_fault    = (l1tlbtol2tlb_req.laddr >> VA_W) != '0;
    assign unused_laddr = ^l1tlbtol2tlb_req.laddr;

    // Next-state, next payload and table-install decode
    always_comb begin
        state_d    = state_q;
        cur_h_d    = cur_h_q;
        cur_core_d = cur_core_q;
        ack_d      = ack_q;
        snoop_d    = snoop_q;
        inst_en    = 1'b0;
        inst_idx   = '0;
        inst_tag   = '0;
        case (state_q)
            IDLE: begin
                if (l1tlbtol2tlb_req_valid) begin
                    cur_h_d    = req_h;
                    cur_core_d = l1tlbtol2tlb_req.coreid;
                    if (req_fault) begin
                        ack_d.coreid = l1tlbtol2tlb_req.coreid;
                        ack_d.hpaddr = '0;
                        ack_d.ppaddr = '0;
                        ack_d.fault  = 3'b001;
                        state_d      = ACK;
                    end else if (slot_valid_q[req_idx] &&
                                 slot_tag_q[req_idx] != req_tag) begin
                        snoop_d.hpaddr = {slot_tag_q[req_idx], req_idx};
                        state_d        = SNOOP;
                    end else begin
                        // Hit and empty slot both ack directly; installing
                        // on a hit rewrites the same tag, so it is harmless.
                        inst_en      = 1'b1;
                        inst_idx     = req_idx;
                        inst_tag     = req_tag;
                        ack_d.coreid = l1tlbtol2tlb_req.coreid;
                        ack_d.hpaddr = req_h;
                        ack_d.ppaddr = req_h[2:0];
                        ack_d.fault  = '0;
                        state_d      = ACK;
                    end
                end
            end
            SNOOP: begin
                if (!l2tlbtol1tlb_snoop_retry)
                    state_d = WAIT_SACK;
            end
            WAIT_SACK: begin
                if (l1tlbtol2tlb_sack_valid &&
                    l1tlbtol2tlb_sack.hpaddr == snoop_q.hpaddr) begin
                    inst_en      = 1'b1;
                    inst_idx     = cur_h_q[IDX_W-1:0];
                    inst_tag     = cur_h_q[10:IDX_W];
                    ack_d.coreid = cur_core_q;
                    ack_d.hpaddr = cur_h_q;
                    ack_d.ppaddr = cur_h_q[2:0];
                    ack_d.fault  = '0;
                    state_d      = ACK;
                end
            end
            ACK: begin
                if (!l2tlbtol1tlb_ack_retry)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, registered outputs and slot valid bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            slot_valid_q  <= '0;
            cur_h_q       <= '0;
            cur_core_q    <= '0;
            ack_q         <= '0;
            snoop_q       <= '0;
            ack_valid_q   <= 1'b0;
            snoop_valid_q <= 1'b0;
            req_retry_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            cur_h_q       <= cur_h_d;
            cur_core_q    <= cur_core_d;
            ack_q         <= ack_d;
            snoop_q       <= snoop_d;
            ack_valid_q   <= (state_d == ACK);
            snoop_valid_q <= (state_d == SNOOP);
            req_retry_q   <= (state_d != IDLE);
            if (inst_en)
                slot_valid_q[inst_idx] <= 1'b1;
        end
    end

    // Slot tags need no reset; they are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (inst_en)
            slot_tag_q[inst_idx] <= inst_tag;
    end

    assign l1tlbtol2tlb_req_retry   = req_retry_q;
    assign l2tlbtol1tlb_ack_valid   = ack_valid_q;
    assign l2tlbtol1tlb_ack         = ack_q;
    assign l2tlbtol1tlb_snoop_valid = snoop_valid_q;
    assign l2tlbtol1tlb_snoop       = snoop_q;
    assign l1tlbtol2tlb_sack_retry  = 1'b0;

endmodule

// File: tb/tb_l2tlb_resp.sv
// Directed bench for l2tlb_resp: reset, fills, hits, conflicts, faults and
// reset during a pending eviction.

module tb_l2tlb_resp;
    import l2tlb_resp_pkg::*;

    logic                clk;
    logic                reset;
    logic                req_valid;
    logic                req_retry;
    I_l1tlbtol2tlb_req   req;
    logic                ack_valid;
    logic                ack_retry;
    I_l2tlbtol1tlb_ack   ack;
    logic                snoop_valid;
    logic                snoop_retry;
    I_l2tlbtol1tlb_snoop snoop;
    logic                sack_valid;
    logic                sack_retry;
    I_l1tlbtol2tlb_sack  sack;

    int n_checks = 0;
    int n_errors = 0;

    l2tlb_resp #(.ENTRIES(16), .VA_W(32)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .l1tlbtol2tlb_req_valid   (req_valid),
        .l1tlbtol2tlb_req_retry   (req_retry),
        .l1tlbtol2tlb_req         (req),
        .l2tlbtol1tlb_ack_valid   (ack_valid),
        .l2tlbtol1tlb_ack_retry   (ack_retry),
        .l2tlbtol1tlb_ack         (ack),
        .l2tlbtol1tlb_snoop_valid (snoop_valid),
        .l2tlbtol1tlb_snoop_retry (snoop_retry),
        .l2tlbtol1tlb_snoop       (snoop),
        .l1tlbtol2tlb_sack_valid  (sack_valid),
        .l1tlbtol2tlb_sack_retry  (sack_retry),
        .l1tlbtol2tlb_sack        (sack)
    );

    // Free-running clock, inputs change and outputs are sampled at negedge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Present one request for a single cycle; DUT must be ready for it
    task automatic issue(input logic [63:0] a, input logic [3:0] c);
        chk("req_ready", req_retry, 0);
        req_valid  = 1'b1;
        req.laddr  = a;
        req.coreid = c;
        cyc();
        req_valid  = 1'b0;
    endtask

    // Expect the ack now, let it transfer, then expect return to idle
    task automatic expect_ack(input string tag, input logic [3:0] c, input logic [10:0] h,
                              input logic [2:0] p, input logic [2:0] f);
        chk({tag, "_ack_valid"}, ack_valid, 1);
        chk({tag, "_snoop_valid"}, snoop_valid, 0);
        chk({tag, "_coreid"}, ack.coreid, c);
        chk({tag, "_hpaddr"}, ack.hpaddr, h);
        chk({tag, "_ppaddr"}, ack.ppaddr, p);
        chk({tag, "_fault"}, ack.fault, f);
        chk({tag, "_busy"}, req_retry, 1);
        cyc();
        chk({tag, "_ack_done"}, ack_valid, 0);
        chk({tag, "_idle"}, req_retry, 0);
    endtask

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req         = '0;
        ack_retry   = 1'b0;
        snoop_retry = 1'b0;
        sack_valid  = 1'b0;
        sack        = '0;

        // T1 reset
        repeat (3) cyc();
        chk("rst_ack_valid", ack_valid, 0);
        chk("rst_snoop_valid", snoop_valid, 0);
        chk("rst_req_retry", req_retry, 1);
        chk("rst_ack_payload", ack, 0);
        chk("rst_snoop_payload", snoop, 0);
        chk("rst_sack_retry", sack_retry, 0);
        reset = 1'b1;
        cyc();

        // T2 cold fill
        issue(64'h0000_5000, 4'd2);
        expect_ack("t2", 4'd2, 11'h005, 3'd5, 3'b000);

        // T3 hit with ack held off for 3 cycles
        ack_retry = 1'b1;
        issue(64'h0000_5000, 4'd2);
        for (int i = 0; i < 3; i++) begin
            chk("t3_held_valid", ack_valid, 1);
            chk("t3_held_hpaddr", ack.hpaddr, 11'h005);
            chk("t3_held_coreid", ack.coreid, 4'd2);
            chk("t3_held_retry", req_retry, 1);
            cyc();
        end
        ack_retry = 1'b0;
        expect_ack("t3", 4'd2, 11'h005, 3'd5, 3'b000);

        // T4 conflict on slot 0
        issue(64'h0001_0000, 4'd1);
        expect_ack("t4a", 4'd1, 11'h010, 3'd0, 3'b000);
        snoop_retry = 1'b1;
        issue(64'h0002_0000, 4'd3);
        chk("t4_snoop_valid", snoop_valid, 1);
        chk("t4_snoop_hpaddr", snoop.hpaddr, 11'h010);
        chk("t4_no_ack", ack_valid, 0);
        cyc();
        chk("t4_snoop_held", snoop_valid, 1);
        chk("t4_snoop_held_hp", snoop.hpaddr, 11'h010);
        snoop_retry = 1'b0;
        cyc();
        chk("t4_snoop_done", snoop_valid, 0);
        chk("t4_wait_busy", req_retry, 1);
        sack_valid  = 1'b1;
        sack.hpaddr = 11'h020;
        cyc();
        chk("t4_wrong_sack_ack", ack_valid, 0);
        chk("t4_wrong_sack_busy", req_retry, 1);
        sack.hpaddr = 11'h010;
        cyc();
        sack_valid = 1'b0;
        expect_ack("t4b", 4'd3, 11'h020, 3'd0, 3'b000);
        issue(64'h0002_0000, 4'd3);
        expect_ack("t4_hit", 4'd3, 11'h020, 3'd0, 3'b000);

        // T5 fault leaves slot 7 untouched
        issue(64'h0000_0100_0000_7000, 4'd1);
        expect_ack("t5_fault", 4'd1, 11'h000, 3'd0, 3'b001);
        issue(64'h0001_7000, 4'd1);
        expect_ack("t5_after", 4'd1, 11'h017, 3'd7, 3'b000);

        // Sack while idle is ignored
        sack_valid  = 1'b1;
        sack.hpaddr = 11'h020;
        cyc();
        sack_valid = 1'b0;
        chk("idle_sack_ack", ack_valid, 0);
        chk("idle_sack_busy", req_retry, 0);

        // T6 reset while waiting for sack
        issue(64'h0003_0000, 4'd2);
        chk("t6_snoop_valid", snoop_valid, 1);
        chk("t6_snoop_hpaddr", snoop.hpaddr, 11'h020);
        cyc();
        chk("t6_wait_busy", req_retry, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_snoop", snoop_valid, 0);
        chk("t6_rst_ack", ack_valid, 0);
        chk("t6_rst_retry", req_retry, 1);
        cyc();
        reset = 1'b1;
        cyc();
        issue(64'h0003_0000, 4'd2);
        expect_ack("t6_refill", 4'd2, 11'h030, 3'd0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
